// File: rtl/cond_pkg.sv
// Shared definitions for the status-flag / condition-evaluation logic:
// flag bit positions, the 4-bit condition field encoding and the flag vector type.
package cond_pkg;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef logic [3:0] flags_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: decodes a 4-bit condition field against
// a {N,Z,C,V} flag vector. Code F follows NV_ALWAYS.
module cond_eval
   import cond_pkg::*;
#(
   parameter bit NV_ALWAYS = 1'b0
) (
   input  logic [3:0] flags_i,
   input  logic [3:0] cond_code_i,
   output logic       pass_o
);

   logic n, z, c, v;

   assign n = flags_i[FLAG_N];
   assign z = flags_i[FLAG_Z];
   assign c = flags_i[FLAG_C];
   assign v = flags_i[FLAG_V];

   always_comb begin
      pass_o = 1'b0;
      case (cond_e'(cond_code_i))
         COND_EQ: pass_o = z;
         COND_NE: pass_o = !z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = !c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = !n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = !v;
         COND_HI: pass_o = c && !z;
         COND_LS: pass_o = !c || z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = !z && (n == v);
         COND_LE: pass_o = z || (n != v);
         COND_AL: pass_o = 1'b1;
         COND_NV: pass_o = NV_ALWAYS;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// N/Z/C/V flag register with per-flag load, condition evaluation, registered
// pass bit and a LIFO flag save/restore stack with sticky over/underflow errors.
module cond_flag_unit
   import cond_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 4,
   parameter bit          NV_ALWAYS   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] flag_in,
   input  logic [3:0] flag_ld,
   input  logic [3:0] cond_code,
   input  logic       cond_en,
   input  logic       push,
   input  logic       pop,
   input  logic       clr_err,
   output logic [3:0] flags,
   output logic       cond_pass,
   output logic       cond_pass_q,
   output logic       stack_full,
   output logic       stack_empty,
   output logic       err_ovf,
   output logic       err_unf
);

   localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   flags_t          flags_q, flags_d;
   logic [CW-1:0]   count_q, count_d;
   logic            cpass_q, cpass_d;
   logic            err_ovf_q, err_ovf_d;
   logic            err_unf_q, err_unf_d;
   flags_t          stack_q [STACK_DEPTH];

   logic [CW-1:0]   count_m1;
   logic [IW-1:0]   push_idx, top_idx;
   logic            full, empty;
   logic            do_push, do_pop, do_xchg;
   logic            pass;

   cond_eval #(.NV_ALWAYS(NV_ALWAYS)) u_eval (
      .flags_i     (flags_q),
      .cond_code_i (cond_code),
      .pass_o      (pass)
   );

   assign full     = (count_q == CW'(STACK_DEPTH));
   assign empty    = (count_q == '0);
   assign count_m1 = count_q - CW'(1);
   assign push_idx = count_q[IW-1:0];
   assign top_idx  = count_m1[IW-1:0];

   // Any pop on a non-empty stack restores flags; push+pop on a non-empty stack is an exchange.
   assign do_pop  = pop && !empty;
   assign do_xchg = pop && push && !empty;
   assign do_push = push && !pop && !full;

   always_comb begin
      flags_d = flags_q;
      if (do_pop) begin
         flags_d = stack_q[top_idx];
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (flag_ld[i]) flags_d[i] = flag_in[i];
         end
      end

      count_d = count_q;
      if (do_push)                    count_d = count_q + CW'(1);
      else if (do_pop && !do_xchg)    count_d = count_m1;

      cpass_d   = cond_en ? pass : cpass_q;
      err_ovf_d = (push && !pop && full) || (err_ovf_q && !clr_err);
      err_unf_d = (pop && empty)         || (err_unf_q && !clr_err);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_q   <= '0;
         count_q   <= '0;
         cpass_q   <= 1'b0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         count_q   <= count_d;
         cpass_q   <= cpass_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   // Entry contents need no reset; the count alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push)      stack_q[push_idx] <= flags_q;
      else if (do_xchg) stack_q[top_idx]  <= flags_q;
   end

   assign flags       = flags_q;
   assign cond_pass   = pass;
   assign cond_pass_q = cpass_q;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign err_ovf     = err_ovf_q;
   assign err_unf     = err_unf_q;

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Parametrised status-flag and condition-evaluation unit for the multi-cycle processor.
- Holds the N/Z/C/V flags with per-flag load enables and evaluates the full 16-entry 4-bit condition field.
- Adds a flag save/restore stack so exception and interrupt entry can preserve and recover flags.
- Sits between the ALU flag outputs and the control FSM; the FSM uses cond_pass to gate PC/register writes.

Parameters:
- STACK_DEPTH, 4, number of flag save entries (≥1).
- NV_ALWAYS, 0, behaviour of code 4'hF: 0 = never pass, 1 = always pass.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-low reset
- flag_in  in  4  ALU flags, bit order {N,Z,C,V} = [3:0]
- flag_ld  in  4  per-flag load enables, same bit order
- cond_code  in  4  condition field from the instruction register
- cond_en  in  1  capture the condition result into cond_pass_q
- push  in  1  save current flags onto the stack
- pop  in  1  restore flags from the stack top
- clr_err  in  1  clear the sticky error flags
- flags  out  4  registered flags {N,Z,C,V}
- cond_pass  out  1  combinational: cond_code evaluated on registered flags
- cond_pass_q  out  1  registered cond_pass
- stack_full  out  1  count == STACK_DEPTH
- stack_empty  out  1  count == 0
- err_ovf  out  1  sticky: push attempted while full
- err_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst = 0, async) values:
  - flags = 4'b0000, cond_pass_q = 0, err_ovf = 0, err_unf = 0.
  - Stack count = 0, so stack_empty = 1 and stack_full = 0.
  - Stack entry contents are don't-care.
- Flag load: for each bit i, flags[i] <= flag_in[i] when flag_ld[i] = 1; otherwise it holds. Flags are visible on the cycle after the load.
- cond_pass decode is purely combinational on registered flags and cond_code:
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV_ALWAYS
- cond_pass_q <= cond_pass when cond_en = 1; otherwise it holds. Latency is 1 cycle.
- Stack is LIFO with count 0..STACK_DEPTH. Operations per cycle:
  - push only, not full: entry[count] <= flags (value before any same-cycle flag_ld); count + 1. Same-cycle flag_ld still updates flags.
  - push only, full: stack and count unchanged; err_ovf <= 1. flag_ld still applies.
  - pop only, not empty: flags <= entry[count−1]; count − 1. flag_ld that cycle is ignored because pop has priority over all bits.
  - pop only, empty: flags follow flag_ld normally; err_unf <= 1.
  - push and pop, not empty: exchange. entry[count−1] <= current flags, flags <= old entry[count−1], count unchanged, flag_ld ignored.
  - push and pop, empty: treated as pop while empty. err_unf <= 1, no push performed, flag_ld applies.
- Errors: err_ovf and err_unf are sticky until clr_err. If clr_err and a new error occur in the same cycle, the new error wins (flag stays 1).
- Async reset mid-operation discards the stack immediately (count = 0). No partial state survives.

Decomposition:
- Shared package cond_pkg:
  - Flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - Condition code constants COND_EQ … COND_NV (4-bit).
  - Flag vector typedef (4 bits).
- Sub-module cond_eval (combinational: flags + cond_code + NV_ALWAYS -> pass). Reused by any future pipelined core.
- Stack and flag registers stay in cond_flag_unit.

Test Plan:
- Reset and load: release rst, then flag_in = 4'b1010 with flag_ld = 4'b1111 -> next cycle flags = 1010 (N = 1, C = 1). cond_code 4'hB (LT) -> cond_pass = 1 since N != V. cond_code 4'hA -> 0.
- Partial load: flags = 1010, then flag_in = 4'b0101 with flag_ld = 4'b0100 -> flags = 1110. cond_code 8 (HI) -> 0, cond_code 9 (LS) -> 1.
- Exhaustive decode: sweep all 16 flag values × 16 codes against a reference model, for NV_ALWAYS = 0 and 1. Check cond_pass_q updates only when cond_en = 1.
- Stack fill/drain, STACK_DEPTH = 4: push flags 1,2,3,4 -> stack_full = 1. A 5th push -> err_ovf = 1 and count stays 4. Pop ×4 -> flags 4,3,2,1, stack_empty = 1. A 5th pop -> err_unf = 1 and flags unchanged.
- Simultaneous ops:
  - flags = 0011 with top entry 1100, push + pop -> flags = 1100, top = 0011, count unchanged.
  - push + flag_ld (flag_in = 1111) with flags = 0001 -> entry = 0001, flags = 1111.
  - clr_err together with an overflowing push -> err_ovf remains 1.
- Reset mid-stack: after 3 pushes, pulse rst low asynchronously (between edges) -> stack_empty = 1 and flags = 0000 immediately. A subsequent pop -> err_unf = 1.
